cr_clk_lpmd_ctrl: RTL and testbench

- Low-power clock-stop controller: the consumer-side counterpart of the clock top.
- Takes the core's WFI/low-power request, drains the bus interface and gates the CPU clock.
- Runs a stop-request/acknowledge handshake with the SoC clock source (PLL/sysio).
- On a wakeup event, releases the clock after a settle delay and reports completion to the core.
- Clocked by the ungated forever clock, so it keeps running while the CPU clock is gated.

---
 rtl/cr_clk_lpmd_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cr_clk_lpmd_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cr_clk_lpmd_ctrl.sv
// Low-power clock-stop controller on the ungated clock: drains the BIU, gates the CPU clock and runs the SoC stop handshake.
// Optional ack timeout in REQ is built when CR_CLK_LPMD_TIMEOUT_EN is defined.
module cr_clk_lpmd_ctrl #(
  parameter int unsigned WAKE_DLY  = 4,
  parameter int unsigned IDLE_FILT = 2,
  parameter int unsigned TMO_CYC   = 64
) (
  input  logic       forever_cpuclk,
  input  logic       cpurst,
  input  logic       core_lpmd_req,
  input  logic [1:0] core_lpmd_mode,
  input  logic       biu_idle,
  input  logic       sysio_clk_ack,
  input  logic       wakeup_event,
  input  logic       pad_yy_test_mode,
  output logic       cpu_clk_en,
  output logic       clk_stop_req,
  output logic [1:0] clk_stop_mode,
  output logic       lpmd_done,
  output logic [1:0] lpmd_status
);

  localparam int unsigned IW = 3;
  localparam int unsigned WW = 4;
  localparam int unsigned TW = $clog2(TMO_CYC + 1);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_REQ   = 3'd2,
    ST_STOP  = 3'd3,
    ST_WAKE  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [IW-1:0] r_idle_cnt;
  logic [IW-1:0] w_idle_cnt_nxt;
  logic [WW-1:0] r_wake_cnt;
  logic [WW-1:0] w_wake_cnt_nxt;
  logic          r_clk_en;
  logic          r_stop_req;
  logic [1:0]    r_mode;
  logic          r_done;
  logic [1:0]    r_status;
  logic          w_clk_en_nxt;
  logic          w_stop_req_nxt;
  logic [1:0]    w_mode_nxt;
  logic          w_done_nxt;
  logic [1:0]    w_status_nxt;

`ifdef CR_CLK_LPMD_TIMEOUT_EN
  logic [TW-1:0] r_tmo_cnt;
  logic [TW-1:0] w_tmo_cnt_nxt;

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) r_tmo_cnt <= '0;
    else        r_tmo_cnt <= w_tmo_cnt_nxt;
  end
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TW'(TMO_CYC);
`endif

  // clk_stop_req/sysio_clk_ack form a four-phase level handshake: req rises, ack rises,
  // req falls, ack falls. WAKE only exits after ack has been seen low, so req cannot re-rise early.
  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = '0;
    w_wake_cnt_nxt = '0;
    w_mode_nxt     = r_mode;
    w_done_nxt     = 1'b0;
`ifdef CR_CLK_LPMD_TIMEOUT_EN
    w_tmo_cnt_nxt  = '0;
`endif
    case (r_state)
      ST_RUN: begin
        if (core_lpmd_req && !pad_yy_test_mode) begin
          w_state_nxt = ST_DRAIN;
          w_mode_nxt  = core_lpmd_mode;
        end
      end
      ST_DRAIN: begin
        if (wakeup_event || !core_lpmd_req || pad_yy_test_mode) begin
          w_state_nxt = ST_RUN;
          w_done_nxt  = 1'b1;
        end else begin
          if (biu_idle)
            w_idle_cnt_nxt = (r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + IW'(1);
          if (w_idle_cnt_nxt >= IW'(IDLE_FILT)) begin
            w_state_nxt    = ST_REQ;
            w_idle_cnt_nxt = '0;
          end
        end
      end
      ST_REQ: begin
        if (pad_yy_test_mode || wakeup_event) begin
          w_state_nxt = ST_WAKE;
        end else if (sysio_clk_ack) begin
          w_state_nxt = ST_STOP;
        end
`ifdef CR_CLK_LPMD_TIMEOUT_EN
        else begin
          w_tmo_cnt_nxt = (r_tmo_cnt == '1) ? r_tmo_cnt : r_tmo_cnt + TW'(1);
          if (w_tmo_cnt_nxt >= TW'(TMO_CYC)) begin
            w_state_nxt   = ST_WAKE;
            w_tmo_cnt_nxt = '0;
          end
        end
`endif
      end
      ST_STOP: begin
        if (pad_yy_test_mode || wakeup_event) w_state_nxt = ST_WAKE;
      end
      ST_WAKE: begin
        // Settle delay only starts once the SoC has dropped its ack.
        if (!sysio_clk_ack)
          w_wake_cnt_nxt = (r_wake_cnt == '1) ? r_wake_cnt : r_wake_cnt + WW'(1);
        if (w_wake_cnt_nxt >= WW'(WAKE_DLY)) begin
          w_state_nxt    = ST_RUN;
          w_done_nxt     = 1'b1;
          w_wake_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_clk_en_nxt   = 1'b0;
    w_stop_req_nxt = 1'b0;
    w_status_nxt   = 2'b00;
    case (w_state_nxt)
      ST_RUN:   begin w_clk_en_nxt = 1'b1; w_status_nxt = 2'b00; end
      ST_DRAIN: begin w_clk_en_nxt = 1'b1; w_status_nxt = 2'b01; end
      ST_REQ:   begin w_stop_req_nxt = 1'b1; w_status_nxt = 2'b01; end
      ST_STOP:  begin w_stop_req_nxt = 1'b1; w_status_nxt = 2'b10; end
      ST_WAKE:  w_status_nxt = 2'b11;
      default:  w_clk_en_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_state    <= ST_RUN;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_clk_en   <= 1'b1;
      r_stop_req <= 1'b0;
      r_mode     <= 2'b00;
      r_done     <= 1'b0;
      r_status   <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_wake_cnt <= w_wake_cnt_nxt;
      r_clk_en   <= w_clk_en_nxt;
      r_stop_req <= w_stop_req_nxt;
      r_mode     <= w_mode_nxt;
      r_done     <= w_done_nxt;
      r_status   <= w_status_nxt;
    end
  end

  assign cpu_clk_en    = r_clk_en | pad_yy_test_mode;
  assign clk_stop_req  = r_stop_req;
  assign clk_stop_mode = r_mode;
  assign lpmd_done     = r_done;
  assign lpmd_status   = r_status;

endmodule

// File: tb/tb_cr_clk_lpmd_ctrl.sv
// Bench for cr_clk_lpmd_ctrl: directed scenarios push timed output snapshots; a negedge monitor pops them on every output change.
module tb_cr_clk_lpmd_ctrl;

  localparam int W = 7;

  logic       forever_cpuclk = 1'b0;
  logic       cpurst = 1'b1;
  logic       core_lpmd_req = 1'b0;
  logic [1:0] core_lpmd_mode = 2'b00;
  logic       biu_idle = 1'b0;
  logic       sysio_clk_ack = 1'b0;
  logic       wakeup_event = 1'b0;
  logic       pad_yy_test_mode = 1'b0;
  logic       cpu_clk_en;
  logic       clk_stop_req;
  logic [1:0] clk_stop_mode;
  logic       lpmd_done;
  logic [1:0] lpmd_status;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  string        exp_name_q[$];

  cr_clk_lpmd_ctrl #(.WAKE_DLY(4), .IDLE_FILT(2), .TMO_CYC(64)) dut (
    .forever_cpuclk   (forever_cpuclk),
    .cpurst           (cpurst),
    .core_lpmd_req    (core_lpmd_req),
    .core_lpmd_mode   (core_lpmd_mode),
    .biu_idle         (biu_idle),
    .sysio_clk_ack    (sysio_clk_ack),
    .wakeup_event     (wakeup_event),
    .pad_yy_test_mode (pad_yy_test_mode),
    .cpu_clk_en       (cpu_clk_en),
    .clk_stop_req     (clk_stop_req),
    .clk_stop_mode    (clk_stop_mode),
    .lpmd_done        (lpmd_done),
    .lpmd_status      (lpmd_status)
  );

  // Clock and cycle stamp
  always #5 forever_cpuclk = ~forever_cpuclk;
  always @(posedge forever_cpuclk) cyc <= cyc + 1;

  // Snapshot layout: {cpu_clk_en, clk_stop_req, clk_stop_mode, lpmd_done, lpmd_status}
  function automatic logic [W-1:0] snap(input logic en, input logic req, input logic [1:0] mode,
                                        input logic done, input logic [1:0] st);
    return {en, req, mode, done, st};
  endfunction

  task automatic expect_at(input int dly, input logic [W-1:0] s, input string nm);
    exp_q.push_back(s);
    exp_cyc_q.push_back(cyc + dly);
    exp_name_q.push_back(nm);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge forever_cpuclk);
      #1;
    end
  endtask

  // Monitor: every change of the output snapshot consumes one expectation
  initial begin : monitor
    logic [W-1:0] prev;
    logic [W-1:0] cur;
    logic [W-1:0] e;
    int           ec;
    string        nm;
    prev = 'x;
    forever begin
      @(negedge forever_cpuclk);
      cur = {cpu_clk_en, clk_stop_req, clk_stop_mode, lpmd_done, lpmd_status};
      if (cur !== prev) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change: got %b at cycle %0d, want no change", cur, cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          nm = exp_name_q.pop_front();
          if (cur !== e || cyc != ec) begin
            fails++;
            $display("FAIL %s: got %b at cycle %0d, want %b at cycle %0d", nm, cur, cyc, e, ec);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin : driver
    expect_at(1, snap(1, 0, 2'd0, 0, 2'd0), "reset_state");
    ticks(3);
    cpurst = 1'b0;
    ticks(2);

    // Full cycle: drain, request, ack, stop, wakeup, settle
    core_lpmd_mode = 2'd2; core_lpmd_req = 1'b1; biu_idle = 1'b1;
    expect_at(1, snap(1, 0, 2'd2, 0, 2'd1), "full_drain");
    expect_at(3, snap(0, 1, 2'd2, 0, 2'd1), "full_req");
    ticks(6);
    sysio_clk_ack = 1'b1;
    expect_at(1, snap(0, 1, 2'd2, 0, 2'd2), "full_stop");
    ticks(10);
    wakeup_event = 1'b1; core_lpmd_req = 1'b0;
    expect_at(1, snap(0, 0, 2'd2, 0, 2'd3), "full_wake");
    ticks(1);
    wakeup_event = 1'b0;
    ticks(2);
    sysio_clk_ack = 1'b0;
    expect_at(4, snap(1, 0, 2'd2, 1, 2'd0), "full_done");
    expect_at(5, snap(1, 0, 2'd2, 0, 2'd0), "full_done_clear");
    ticks(8);

    // Drain filter: idle pattern 1,0,1,1
    core_lpmd_mode = 2'd1; core_lpmd_req = 1'b1; biu_idle = 1'b0;
    expect_at(1, snap(1, 0, 2'd1, 0, 2'd1), "filt_drain");
    ticks(1); biu_idle = 1'b1;
    ticks(1); biu_idle = 1'b0;
    ticks(1); biu_idle = 1'b1;
    ticks(1);
    expect_at(1, snap(0, 1, 2'd1, 0, 2'd1), "filt_req");
    ticks(2);
    wakeup_event = 1'b1; core_lpmd_req = 1'b0;
    expect_at(1, snap(0, 0, 2'd1, 0, 2'd3), "filt_wake_from_req");
    expect_at(5, snap(1, 0, 2'd1, 1, 2'd0), "filt_done");
    expect_at(6, snap(1, 0, 2'd1, 0, 2'd0), "filt_done_clear");
    ticks(1);
    wakeup_event = 1'b0;
    ticks(7);

    // Abort in DRAIN
    core_lpmd_mode = 2'd3; core_lpmd_req = 1'b1; biu_idle = 1'b0;
    expect_at(1, snap(1, 0, 2'd3, 0, 2'd1), "abort_drain");
    ticks(1);
    wakeup_event = 1'b1; core_lpmd_req = 1'b0;
    expect_at(1, snap(1, 0, 2'd3, 1, 2'd0), "abort_done");
    expect_at(2, snap(1, 0, 2'd3, 0, 2'd0), "abort_done_clear");
    ticks(1);
    wakeup_event = 1'b0;
    ticks(3);

    // Wakeup coincident with the request still enters DRAIN first
    core_lpmd_mode = 2'd0; core_lpmd_req = 1'b1; wakeup_event = 1'b1;
    expect_at(1, snap(1, 0, 2'd0, 0, 2'd1), "coinc_drain");
    expect_at(2, snap(1, 0, 2'd0, 1, 2'd0), "coinc_done");
    expect_at(3, snap(1, 0, 2'd0, 0, 2'd0), "coinc_done_clear");
    ticks(2);
    core_lpmd_req = 1'b0; wakeup_event = 1'b0;
    ticks(3);

    // Test mode asserted in STOP
    core_lpmd_mode = 2'd1; core_lpmd_req = 1'b1; biu_idle = 1'b1;
    expect_at(1, snap(1, 0, 2'd1, 0, 2'd1), "tm_drain");
    expect_at(3, snap(0, 1, 2'd1, 0, 2'd1), "tm_req");
    ticks(3);
    sysio_clk_ack = 1'b1;
    expect_at(1, snap(0, 1, 2'd1, 0, 2'd2), "tm_stop");
    ticks(3);
    pad_yy_test_mode = 1'b1; core_lpmd_req = 1'b0;
    expect_at(0, snap(1, 1, 2'd1, 0, 2'd2), "tm_clk_en_same_cycle");
    expect_at(1, snap(1, 0, 2'd1, 0, 2'd3), "tm_wake");
    ticks(3);
    sysio_clk_ack = 1'b0;
    expect_at(4, snap(1, 0, 2'd1, 1, 2'd0), "tm_done");
    expect_at(5, snap(1, 0, 2'd1, 0, 2'd0), "tm_done_clear");
    ticks(6);
    core_lpmd_req = 1'b1;
    ticks(3);
    core_lpmd_req = 1'b0;
    ticks(1);
    pad_yy_test_mode = 1'b0;
    ticks(2);

    // Reset during STOP
    core_lpmd_mode = 2'd2; core_lpmd_req = 1'b1; biu_idle = 1'b1;
    expect_at(1, snap(1, 0, 2'd2, 0, 2'd1), "rst_drain");
    expect_at(3, snap(0, 1, 2'd2, 0, 2'd1), "rst_req");
    ticks(3);
    sysio_clk_ack = 1'b1;
    expect_at(1, snap(0, 1, 2'd2, 0, 2'd2), "rst_stop");
    ticks(2);
    cpurst = 1'b1; core_lpmd_req = 1'b0;
    expect_at(0, snap(1, 0, 2'd0, 0, 2'd0), "rst_mid_stop");
    ticks(1);
    cpurst = 1'b0; sysio_clk_ack = 1'b0;
    ticks(4);

    // Ack never arrives
    core_lpmd_mode = 2'd3; core_lpmd_req = 1'b1; biu_idle = 1'b1;
    expect_at(1, snap(1, 0, 2'd3, 0, 2'd1), "noack_drain");
    expect_at(3, snap(0, 1, 2'd3, 0, 2'd1), "noack_req");
    ticks(4);
    core_lpmd_req = 1'b0;
`ifdef CR_CLK_LPMD_TIMEOUT_EN
    expect_at(63, snap(0, 0, 2'd3, 0, 2'd3), "tmo_expire");
    expect_at(67, snap(1, 0, 2'd3, 1, 2'd0), "tmo_done");
    expect_at(68, snap(1, 0, 2'd3, 0, 2'd0), "tmo_done_clear");
    ticks(75);
`else
    ticks(66);
    wakeup_event = 1'b1;
    expect_at(1, snap(0, 0, 2'd3, 0, 2'd3), "noack_wake");
    expect_at(5, snap(1, 0, 2'd3, 1, 2'd0), "noack_done");
    expect_at(6, snap(1, 0, 2'd3, 0, 2'd0), "noack_done_clear");
    ticks(1);
    wakeup_event = 1'b0;
    ticks(8);
`endif

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) ticks(1);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations: got %0d left, want 0 (next %s)", exp_q.size(), exp_name_q[0]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
